// File: rtl/everloop_frame_ctrl_if.sv
// rtl/everloop_frame_ctrl_if.sv - host/driver bus bundle for the everloop frame controller
//
// Purpose: groups the host write/fill/commit controls, the LED driver read
//          port and the status outputs of everloop_frame_ctrl.
// Ports (signals):
//   wr_en, wr_addr, wr_data   host byte write into the back bank
//   fill_req, fill_data       host request to fill the whole back bank
//   commit                    host request to swap banks at next frame boundary
//   drv_addr, drv_data        driver read port on the front bank
//   wr_ack, rej               accept / reject pulses for last-cycle host events
//   busy, commit_pending      fill in progress / swap waiting for boundary
//   frame_swapped, frame_cnt  swap pulse / driver frame boundary counter
// Modports: master = host + driver side, slave = controller side.
interface everloop_frame_ctrl_if #(
   parameter int AW = 8,
   parameter int CW = 16
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          fill_req;
   logic [7:0]    fill_data;
   logic          commit;
   logic [AW-1:0] drv_addr;
   logic [7:0]    drv_data;
   logic          wr_ack;
   logic          rej;
   logic          busy;
   logic          commit_pending;
   logic          frame_swapped;
   logic [CW-1:0] frame_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, fill_req, fill_data, commit, drv_addr,
      input  drv_data, wr_ack, rej, busy, commit_pending, frame_swapped, frame_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, fill_req, fill_data, commit, drv_addr,
      output drv_data, wr_ack, rej, busy, commit_pending, frame_swapped, frame_cnt
   );
endinterface

// File: rtl/everloop_frame_ctrl.sv
// rtl/everloop_frame_ctrl.sv - double-buffered LED frame memory controller
//
// Purpose: two banks of N_BYTES LED bytes. The driver reads the front bank,
//          the host writes or fills the back bank; a commit swaps the banks
//          only at the next driver frame boundary so a frame is never torn.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (RAM contents are kept)
//   bus   everloop_frame_ctrl_if.slave - host controls, driver read, status
module everloop_frame_ctrl #(
   parameter int N_BYTES = 141,
   parameter int AW      = 8,
   parameter int CW      = 16
) (
   input logic                  clk,
   input logic                  rst,
   everloop_frame_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      FILL        = 2'd1,
      COMMIT_WAIT = 2'd2
   } state_t;

   localparam logic [AW-1:0] END_ADDR  = AW'(N_BYTES);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N_BYTES - 1);

   state_t        state;
   state_t        state_nxt;

   logic [7:0]    bank0 [N_BYTES];
   logic [7:0]    bank1 [N_BYTES];

   logic          front_sel;
   logic [AW-1:0] drv_addr_q;
   logic [AW-1:0] fill_cnt;
   logic [7:0]    fill_data_q;
   logic [7:0]    drv_data;
   logic          wr_ack;
   logic          rej;
   logic          frame_swapped;
   logic [CW-1:0] frame_cnt;

   logic          boundary;
   logic          wr_in_range;
   logic          rd_in_range;
   logic          host_any;
   logic          fill_last;

   logic          busy;
   logic          commit_pending;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic          ack_nxt;
   logic          rej_nxt;
   logic          swap_now;
   logic          fill_start;

   // A frame ends when the driver has stepped one past the last byte and
   // then restarts at 0; a plain jump to 0 from elsewhere is not a boundary.
   assign boundary    = (drv_addr_q == END_ADDR) && (bus.drv_addr == '0);
   assign wr_in_range = bus.wr_addr < END_ADDR;
   assign rd_in_range = bus.drv_addr < END_ADDR;
   assign host_any    = bus.wr_en | bus.fill_req | bus.commit;
   assign fill_last   = fill_cnt == LAST_ADDR;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; fill wins over a simultaneous commit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.fill_req) begin
               state_nxt = FILL;
            end else if (bus.commit) begin
               state_nxt = COMMIT_WAIT;
            end
         end
         FILL: begin
            if (fill_last) begin
               state_nxt = IDLE;
            end
         end
         COMMIT_WAIT: begin
            if (boundary) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath control decode
   always_comb begin
      busy           = 1'b0;
      commit_pending = 1'b0;
      mem_we         = 1'b0;
      mem_waddr      = bus.wr_addr;
      mem_wdata      = bus.wr_data;
      ack_nxt        = 1'b0;
      rej_nxt        = 1'b0;
      swap_now       = 1'b0;
      fill_start     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.wr_en) begin
               if (wr_in_range) begin
                  mem_we  = 1'b1;
                  ack_nxt = 1'b1;
               end else begin
                  rej_nxt = 1'b1;
               end
            end
            fill_start = bus.fill_req;
            if (bus.fill_req && bus.commit) begin
               rej_nxt = 1'b1;
            end
         end
         FILL: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = fill_cnt;
            mem_wdata = fill_data_q;
            rej_nxt   = host_any;
         end
         COMMIT_WAIT: begin
            commit_pending = 1'b1;
            rej_nxt        = host_any;
            swap_now       = boundary;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Back-bank write port; a reset cycle never writes so a reset mid-fill
   // leaves exactly the bytes written before it.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         if (front_sel) begin
            bank0[mem_waddr] <= mem_wdata;
         end else begin
            bank1[mem_waddr] <= mem_wdata;
         end
      end
   end

   // Front-bank read, frame tracking, bank swap and status pulses. The read
   // in the swap cycle still uses the old front bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         front_sel     <= 1'b0;
         drv_addr_q    <= '0;
         drv_data      <= '0;
         wr_ack        <= 1'b0;
         rej           <= 1'b0;
         frame_swapped <= 1'b0;
         frame_cnt     <= '0;
         fill_cnt      <= '0;
         fill_data_q   <= '0;
      end else begin
         drv_addr_q    <= bus.drv_addr;
         wr_ack        <= ack_nxt;
         rej           <= rej_nxt;
         frame_swapped <= swap_now;
         if (boundary) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (swap_now) begin
            front_sel <= ~front_sel;
         end
         if (fill_start) begin
            fill_cnt    <= '0;
            fill_data_q <= bus.fill_data;
         end else if (busy) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
         if (rd_in_range) begin
            drv_data <= front_sel ? bank1[bus.drv_addr] : bank0[bus.drv_addr];
         end else begin
            drv_data <= '0;
         end
      end
   end

   assign bus.drv_data       = drv_data;
   assign bus.wr_ack         = wr_ack;
   assign bus.rej            = rej;
   assign bus.busy           = busy;
   assign bus.commit_pending = commit_pending;
   assign bus.frame_swapped  = frame_swapped;
   assign bus.frame_cnt      = frame_cnt;

endmodule

// File: tb/tb_everloop_frame_ctrl.sv
// tb/tb_everloop_frame_ctrl.sv - self-checking bench for everloop_frame_ctrl
module tb_everloop_frame_ctrl;

   localparam int N = 141;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   everloop_frame_ctrl_if #(.AW(8), .CW(16)) bus ();

   everloop_frame_ctrl #(.N_BYTES(N), .AW(8), .CW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: memory image per bank, which bank is visible, how many
   // fill bytes remain, whether a swap is owed, and the last driver address.
   logic [7:0] mm    [2][N];
   bit         known [2][N];
   int         front;
   int         fill_left;
   logic [7:0] fill_val;
   bit         pending;
   int         prev_addr;
   int         cnt;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.fill_req  = 1'b0;
      bus.fill_data = '0;
      bus.commit    = 1'b0;
      bus.drv_addr  = 8'd200;
      rst           = 1'b0;
   endtask

   // Predict one clock from the current inputs, clock it, then compare.
   task automatic tick();
      logic [7:0] e_data;
      bit e_ack, e_rej, e_swap, bd, chk_data, any;
      int b, da;
      e_ack = 0; e_rej = 0; e_swap = 0; e_data = 8'h00; chk_data = 1;
      da  = int'(bus.drv_addr);
      any = bus.wr_en || bus.fill_req || bus.commit;
      if (rst) begin
         front = 0; fill_left = 0; pending = 0; cnt = 0; prev_addr = 0;
      end else begin
         bd = (prev_addr == N) && (da == 0);
         if (da < N) begin
            e_data   = mm[front][da];
            chk_data = known[front][da];
         end
         b = 1 - front;
         if (fill_left > 0) begin
            mm[b][N - fill_left]    = fill_val;
            known[b][N - fill_left] = 1;
            fill_left--;
            if (any) e_rej = 1;
         end else if (pending) begin
            if (any) e_rej = 1;
            if (bd) begin
               front = b; pending = 0; e_swap = 1;
            end
         end else begin
            if (bus.wr_en) begin
               if (int'(bus.wr_addr) < N) begin
                  mm[b][int'(bus.wr_addr)]    = bus.wr_data;
                  known[b][int'(bus.wr_addr)] = 1;
                  e_ack = 1;
               end else begin
                  e_rej = 1;
               end
            end
            if (bus.fill_req) begin
               fill_left = N;
               fill_val  = bus.fill_data;
               if (bus.commit) e_rej = 1;
            end else if (bus.commit) begin
               pending = 1;
            end
         end
         if (bd) cnt = (cnt + 1) % 65536;
         prev_addr = da;
      end
      @(posedge clk);
      #1;
      chk("wr_ack", 32'(bus.wr_ack), 32'(e_ack));
      chk("rej", 32'(bus.rej), 32'(e_rej));
      chk("busy", 32'(bus.busy), 32'(fill_left > 0));
      chk("commit_pending", 32'(bus.commit_pending), 32'(pending));
      chk("frame_swapped", 32'(bus.frame_swapped), 32'(e_swap));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(cnt));
      if (chk_data) chk("drv_data", 32'(bus.drv_data), 32'(e_data));
   endtask

   // Driver walks 0..N then restarts at 0, producing one frame boundary.
   task automatic sweep();
      bus.wr_en = 1'b0; bus.fill_req = 1'b0; bus.commit = 1'b0;
      for (int a = 0; a <= N; a++) begin
         bus.drv_addr = 8'(a);
         tick();
      end
      bus.drv_addr = 8'd0;
      tick();
   endtask

   task automatic do_fill(input logic [7:0] v);
      bus.fill_req = 1'b1; bus.fill_data = v;
      tick();
      bus.fill_req = 1'b0;
      repeat (N) tick();
   endtask

   task automatic do_commit();
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
   endtask

   initial begin
      int da;
      front = 0; fill_left = 0; pending = 0; prev_addr = 0; cnt = 0; fill_val = 0;

      // Reset state
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_drv_data", 32'(bus.drv_data), 32'h0);

      // Bring both banks to known contents: bank1 = 0x11, bank0 = 0x22
      do_fill(8'h11);
      do_commit();
      sweep();
      do_fill(8'h22);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Host write to back bank is invisible to the driver
      bus.wr_en = 1'b1; bus.wr_addr = 8'd5; bus.wr_data = 8'hA5; bus.drv_addr = 8'd5;
      tick();
      bus.wr_en = 1'b0;
      tick();
      chk("front_untouched", 32'(bus.drv_data != 8'hA5), 32'h1);

      // Fill 0x3C, commit, swap at boundary, read the whole new front
      do_fill(8'h3C);
      do_commit();
      sweep();
      sweep();

      // Rejections in IDLE, FILL and COMMIT_WAIT
      bus.wr_en = 1'b1; bus.wr_addr = 8'd141; bus.wr_data = 8'hEE;
      tick();
      bus.wr_en = 1'b0;
      bus.fill_req = 1'b1; bus.fill_data = 8'h77;
      tick();
      bus.fill_req = 1'b0;
      bus.wr_en = 1'b1; bus.wr_addr = 8'd3; tick(); bus.wr_en = 1'b0;
      bus.commit = 1'b1; tick(); bus.commit = 1'b0;
      bus.fill_req = 1'b1; bus.fill_data = 8'h99; tick(); bus.fill_req = 1'b0;
      repeat (N - 3) tick();
      do_commit();
      bus.wr_en = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = 8'h01; tick(); bus.wr_en = 1'b0;
      bus.fill_req = 1'b1; tick(); bus.fill_req = 1'b0;
      bus.commit = 1'b1; tick(); bus.commit = 1'b0;
      sweep();
      sweep();

      // Commit arriving on a boundary waits for the following one
      for (int a = 0; a <= N; a++) begin
         bus.drv_addr = 8'(a);
         tick();
      end
      bus.drv_addr = 8'd0; bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("commit_on_boundary_pending", 32'(bus.commit_pending), 32'h1);
      sweep();
      sweep();

      // fill_req with commit: fill wins, commit rejected
      bus.fill_req = 1'b1; bus.fill_data = 8'h5A; bus.commit = 1'b1;
      tick();
      bus.fill_req = 1'b0; bus.commit = 1'b0;
      repeat (N) tick();

      // Write together with commit lands before the swap
      bus.wr_en = 1'b1; bus.wr_addr = 8'd10; bus.wr_data = 8'h55; bus.commit = 1'b1;
      tick();
      bus.wr_en = 1'b0; bus.commit = 1'b0;
      sweep();
      bus.drv_addr = 8'd10;
      tick();
      tick();
      chk("wr_with_commit_visible", 32'(bus.drv_data), 32'h55);

      // Reset 20 cycles into a fill
      bus.fill_req = 1'b1; bus.fill_data = 8'hC3;
      tick();
      bus.fill_req = 1'b0;
      repeat (20) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      bus.drv_addr = 8'd141;
      tick();

      // Reset while a swap is pending
      do_commit();
      repeat (3) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      bus.drv_addr = 8'd141;
      tick();
      sweep();

      // Randomized traffic with a mostly sequential driver
      da = 0;
      for (int i = 0; i < 3000; i++) begin
         bus.wr_en     = ($urandom_range(0, 99) < 20);
         bus.wr_addr   = 8'($urandom_range(0, 150));
         bus.wr_data   = 8'($urandom);
         bus.fill_req  = ($urandom_range(0, 99) < 2);
         bus.fill_data = 8'($urandom);
         bus.commit    = ($urandom_range(0, 99) < 5);
         da = (da >= N) ? 0 : da + 1;
         if ($urandom_range(0, 99) < 3) da = $urandom_range(0, 255);
         bus.drv_addr  = 8'(da);
         rst           = ($urandom_range(0, 499) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
